// File: rtl/cmsdk_gpio_in_filter.sv
// GPIO input conditioning: per-pin pad synchroniser plus programmable run-length debounce feeding PORTIN.
// Define GPIO_IN_FILTER_EDGE_EN to build the registered RISE/FALL edge-pulse outputs; otherwise they are tied low.
module cmsdk_gpio_in_filter #(
   parameter int          SYNC_STAGES = 2,
   parameter int          CNT_W       = 8,
   parameter logic [15:0] RESET_VAL   = 16'h0000
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic [15:0]      PADIN,
   input  logic [15:0]      FILTEN,
   input  logic [CNT_W-1:0] DBLIMIT,
   output logic [15:0]      PORTIN_F,
   output logic [15:0]      RISE,
   output logic [15:0]      FALL
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [15:0]      sync_q [SYNC_STAGES];
   logic [15:0]      sync_s;
   logic [15:0]      portin_q, portin_d;
   logic [CNT_W-1:0] cnt_q [16];
   logic [CNT_W-1:0] cnt_d [16];
   logic [CNT_W-1:0] lim_m1;

   // Plain flop chain; nothing may be inserted between stages.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= RESET_VAL;
         end
      end else begin
         sync_q[0] <= PADIN;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   // DBLIMIT of zero is treated as a run length of one.
   assign lim_m1 = (DBLIMIT == '0) ? '0 : (DBLIMIT - CNT_ONE);

   always_comb begin
      portin_d = portin_q;
      for (int i = 0; i < 16; i++) begin
         cnt_d[i] = '0;
         if (!FILTEN[i]) begin
            portin_d[i] = sync_s[i];
         end else if (sync_s[i] != portin_q[i]) begin
            if (cnt_q[i] >= lim_m1) begin
               portin_d[i] = sync_s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         portin_q <= RESET_VAL;
         for (int i = 0; i < 16; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         portin_q <= portin_d;
         cnt_q    <= cnt_d;
      end
   end

   assign PORTIN_F = portin_q;

`ifdef GPIO_IN_FILTER_EDGE_EN
   logic [15:0] rise_q, fall_q;

   // Pulses are registered alongside the PORTIN_F update so they align with the new value.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= portin_d & ~portin_q;
         fall_q <= ~portin_d & portin_q;
      end
   end

   assign RISE = rise_q;
   assign FALL = fall_q;
`else
   assign RISE = 16'h0000;
   assign FALL = 16'h0000;
`endif

endmodule

// File: tb/tb_cmsdk_gpio_in_filter.sv
// Bench for cmsdk_gpio_in_filter: directed latency/boundary cases plus random traffic against a run-length reference model.
module tb_cmsdk_gpio_in_filter;

   localparam int          SYNC = 2;
   localparam int          CW   = 8;
   localparam logic [15:0] RV   = 16'h0000;
`ifdef GPIO_IN_FILTER_EDGE_EN
   localparam bit EDGE_ON = 1'b1;
`else
   localparam bit EDGE_ON = 1'b0;
`endif

   logic          HCLK    = 1'b0;
   logic          HRESET  = 1'b1;
   logic [15:0]   PADIN   = '0;
   logic [15:0]   FILTEN  = '0;
   logic [CW-1:0] DBLIMIT = '0;
   logic [15:0]   PORTIN_F, RISE, FALL;

   always #5 HCLK = ~HCLK;

   cmsdk_gpio_in_filter #(
      .SYNC_STAGES(SYNC),
      .CNT_W      (CW),
      .RESET_VAL  (RV)
   ) dut (
      .HCLK    (HCLK),
      .HRESET  (HRESET),
      .PADIN   (PADIN),
      .FILTEN  (FILTEN),
      .DBLIMIT (DBLIMIT),
      .PORTIN_F(PORTIN_F),
      .RISE    (RISE),
      .FALL    (FALL)
   );

   int checks = 0;
   int errors = 0;
   logic [47:0] exp_q [$];
   logic [47:0] mon_e;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: pad history gives the synchronised view; each pin adopts that view
   // once it has disagreed with the output for L consecutive cycles.
   logic [15:0] m_out;
   int          m_run [16];
   logic [15:0] m_hist [$];

   task automatic model_reset();
      m_out = RV;
      foreach (m_run[i]) m_run[i] = 0;
      m_hist.delete();
      repeat (SYNC) m_hist.push_back(RV);
   endtask

   task automatic model_step(input logic [15:0] pad, input logic [15:0] fen, input int lim,
                             output logic [47:0] e);
      logic [15:0] s, prev;
      int l;
      s = m_hist.pop_front();
      m_hist.push_back(pad);
      prev = m_out;
      l = (lim == 0) ? 1 : lim;
      for (int i = 0; i < 16; i++) begin
         if (!fen[i]) begin
            m_out[i] = s[i];
            m_run[i] = 0;
         end else if (s[i] == m_out[i]) begin
            m_run[i] = 0;
         end else begin
            m_run[i]++;
            if (m_run[i] >= l) begin
               m_out[i] = s[i];
               m_run[i] = 0;
            end
         end
      end
      e = {m_out, EDGE_ON ? (m_out & ~prev) : 16'h0, EDGE_ON ? (~m_out & prev) : 16'h0};
   endtask

   task automatic step(input logic rst, input logic [15:0] pad, input logic [15:0] fen,
                       input logic [CW-1:0] lim);
      logic [47:0] e;
      @(negedge HCLK);
      HRESET  = rst;
      PADIN   = pad;
      FILTEN  = fen;
      DBLIMIT = lim;
      if (rst) begin
         model_reset();
      end else begin
         model_step(pad, fen, int'(lim), e);
         exp_q.push_back(e);
      end
      @(posedge HCLK);
      #2;
   endtask

   // Holds inputs until PORTIN_F[idx]==val; k = edges taken, -1 if the bound expires.
   task automatic run_until(input int idx, input logic val, input logic [15:0] pad,
                            input logic [15:0] fen, input logic [CW-1:0] lim,
                            input int max, output int k);
      k = -1;
      for (int n = 1; n <= max; n++) begin
         step(1'b0, pad, fen, lim);
         if (PORTIN_F[idx] === val) begin
            k = n;
            break;
         end
      end
   endtask

   always begin
      @(posedge HCLK);
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("scoreboard", {PORTIN_F, RISE, FALL}, mon_e);
      end
   end

   initial begin
      int          k;
      logic        seen;
      logic [15:0] pad, fen;
      logic [CW-1:0] lim;

      // Reset held with all pads high
      for (int n = 0; n < 3; n++) begin
         step(1'b1, 16'hFFFF, 16'h0000, 8'd0);
         check("reset_hold", {PORTIN_F, RISE, FALL}, {RV, 32'h0});
      end

      // Bypass latency on pin 3
      repeat (4) step(1'b0, 16'h0000, 16'h0000, 8'd0);
      run_until(3, 1'b1, 16'h0008, 16'h0000, 8'd0, 20, k);
      check("bypass_latency", 48'(k), 48'(SYNC + 1));
      check("bypass_rise", 48'(RISE), 48'(EDGE_ON ? 16'h0008 : 16'h0000));
      step(1'b0, 16'h0008, 16'h0000, 8'd0);
      check("bypass_rise_one_cycle", 48'(RISE), 48'h0);

      // Debounce with L=4: 3-cycle glitch rejected, 4-cycle run accepted
      repeat (10) step(1'b0, 16'h0000, 16'hFFFF, 8'd4);
      seen = 1'b0;
      for (int n = 0; n < 3; n++) begin
         step(1'b0, 16'h0001, 16'hFFFF, 8'd4);
         seen |= PORTIN_F[0];
      end
      for (int n = 0; n < 10; n++) begin
         step(1'b0, 16'h0000, 16'hFFFF, 8'd4);
         seen |= PORTIN_F[0];
      end
      check("glitch3_rejected", 48'(seen), 48'h0);
      run_until(0, 1'b1, 16'h0001, 16'hFFFF, 8'd4, 20, k);
      check("debounce4_latency", 48'(k), 48'(SYNC + 4));

      // DBLIMIT=0 acts as 1
      run_until(1, 1'b1, 16'h0003, 16'hFFFF, 8'd0, 20, k);
      check("dblimit0_latency", 48'(k), 48'(SYNC + 1));
      run_until(1, 1'b0, 16'h0001, 16'hFFFF, 8'd1, 20, k);
      check("dblimit1_latency", 48'(k), 48'(SYNC + 1));

      // DBLIMIT cut from 200 to 5 once the run has reached 50
      k = -1;
      for (int n = 1; n <= SYNC + 60; n++) begin
         step(1'b0, 16'h0005, 16'hFFFF, (n <= SYNC + 50) ? 8'd200 : 8'd5);
         if (PORTIN_F[2] === 1'b1) begin
            k = n;
            break;
         end
      end
      check("dblimit_cut", 48'(k), 48'(SYNC + 51));

      // DBLIMIT=255: 254-cycle run rejected, 255-cycle run accepted
      seen = 1'b0;
      for (int n = 0; n < 254; n++) begin
         step(1'b0, 16'h0015, 16'hFFFF, 8'hFF);
         seen |= PORTIN_F[4];
      end
      for (int n = 0; n < 10; n++) begin
         step(1'b0, 16'h0005, 16'hFFFF, 8'hFF);
         seen |= PORTIN_F[4];
      end
      check("run254_rejected", 48'(seen), 48'h0);
      run_until(4, 1'b1, 16'h0015, 16'hFFFF, 8'hFF, 300, k);
      check("run255_latency", 48'(k), 48'(SYNC + 255));

      // Concurrency: high byte bypassed, low byte filtered with L=3
      repeat (20) step(1'b0, 16'h0000, 16'h00FF, 8'd3);
      repeat (SYNC) step(1'b0, 16'hA5A5, 16'h00FF, 8'd3);
      check("conc_before", 48'(PORTIN_F), 48'h0);
      step(1'b0, 16'hA5A5, 16'h00FF, 8'd3);
      check("conc_high_byte", {16'h0, PORTIN_F, RISE},
            {16'h0, 16'hA500, EDGE_ON ? 16'hA500 : 16'h0000});
      step(1'b0, 16'hA5A5, 16'h00FF, 8'd3);
      step(1'b0, 16'hA5A5, 16'h00FF, 8'd3);
      check("conc_low_byte", {16'h0, PORTIN_F, RISE},
            {16'h0, 16'hA5A5, EDGE_ON ? 16'h00A5 : 16'h0000});

      // Random traffic with occasional FILTEN/DBLIMIT changes and resets
      pad = 16'hA5A5;
      fen = 16'h00FF;
      lim = 8'd3;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 63) == 0) fen = 16'($urandom);
         if ($urandom_range(0, 49) == 0) lim = 8'($urandom_range(0, 6));
         pad = pad ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
         step(($urandom_range(0, 499) == 0), pad, fen, lim);
      end

      // Asynchronous reset asserted between edges
      repeat (6) step(1'b0, 16'hFFFF, 16'h0000, 8'd0);
      check("pre_async_all_high", 48'(PORTIN_F), 48'hFFFF);
      #1;
      HRESET = 1'b1;
      #1;
      check("async_reset_immediate", {PORTIN_F, RISE, FALL}, {RV, 32'h0});
      model_reset();
      step(1'b1, 16'hFFFF, 16'h0000, 8'd0);
      repeat (8) step(1'b0, 16'hFFFF, 16'h0000, 8'd0);

      repeat (3) @(posedge HCLK);
      #3;
      check("scoreboard_drained", 48'(exp_q.size()), 48'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
